// File: rtl/door_motion_conditioner.sv
// door_motion_conditioner: synchronises and debounces the raw door motion
// sensor, stretches the motion level by a hold time, and traps a stuck-high
// sensor in a fail-secure fault state until software clears it.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no motion, waiting for synchronised input to go high
// QUALIFY | input high, counting consecutive high samples (debounce)
// ACTIVE  | motion reported, counting consecutive high cycles (stuck watch)
// HOLD    | input dropped, motion still reported until hold time expires
// FAULT   | stuck sensor, motion forced low until clear_fault with input low

`ifndef DOOR_MOTION_SENSOR_DATA_WIDTH
`define DOOR_MOTION_SENSOR_DATA_WIDTH 1
`endif

module door_motion_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1000,
  parameter int STUCK_CYCLES    = 100000,
  parameter int CNT_W           = 20
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       raw_motion,
  input  logic                                       clear_fault,
  output logic [`DOOR_MOTION_SENSOR_DATA_WIDTH-1:0] door_motion_sensor,
  output logic                                       sensor_fault,
  output logic [2:0]                                 state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUALIFY = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  // Terminal counts; the shared counter is compared against these, never wraps.
  localparam logic [CNT_W-1:0] DEB_TC   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STUCK_TC = CNT_W'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             motion_q, motion_d;
  logic             fault_q, fault_d;

  // Shift raw input through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_motion};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Next-state, counter and output decode; outputs follow the next state so
  // they are registered together with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (s) begin
          state_d = (DEBOUNCE_CYCLES == 1) ? ST_ACTIVE : ST_QUALIFY;
          cnt_d   = CNT_ONE;
        end
      end
      ST_QUALIFY: begin
        if (!s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_TC) begin
          state_d = ST_ACTIVE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_ACTIVE: begin
        // A falling input beats the stuck terminal count.
        if (!s) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == STUCK_TC) begin
          state_d = ST_FAULT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HOLD: begin
        // A retrigger beats the hold terminal count.
        if (s) begin
          state_d = ST_ACTIVE;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == HOLD_TC) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_FAULT: begin
        cnt_d = '0;
        if (clear_fault && !s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    motion_d = (state_d == ST_ACTIVE) || (state_d == ST_HOLD);
    fault_d  = (state_d == ST_FAULT);
  end

  // FSM state, shared counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      motion_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      motion_q <= motion_d;
      fault_q  <= fault_d;
    end
  end

  // Drive level on bit 0, upper bits held at zero.
  always_comb begin
    door_motion_sensor    = '0;
    door_motion_sensor[0] = motion_q;
  end

  assign sensor_fault = fault_q;
  assign state_dbg    = state_q;

endmodule

// File: doc/door_motion_conditioner.md
Name: door_motion_conditioner

Overview:
- Conditions the raw door PIR/contact motion input into the clean `door_motion_sensor` level that feeds door_lock_system directly downstream.
- Synchronises the asynchronous raw input, then debounces it.
- Holds motion asserted for a programmable time after the last activity, so the lock does not chatter.
- Detects a stuck-high sensor and forces a fail-secure output (motion = 0, so the door locks) until software clears the fault.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the raw-input synchroniser (minimum 2)
DEBOUNCE_CYCLES, 16, consecutive synchronised-high samples required to qualify motion (minimum 1)
HOLD_CYCLES, 1000, cycles the output stays high after the synchronised input drops (minimum 1)
STUCK_CYCLES, 100000, consecutive synchronised-high cycles in ACTIVE that declare a stuck sensor
CNT_W, 20, width of the shared internal counter; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, HOLD_CYCLES, STUCK_CYCLES)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
raw_motion  input  1  unsynchronised sensor input, active high
clear_fault  input  1  synchronous single-cycle pulse; clears sensor_fault
door_motion_sensor  output  `door_motion_sensor_data_width (1)  conditioned motion level for door_lock_system; bit 0 carries the level, upper bits (if any) are 0
sensor_fault  output  1  sticky stuck-sensor flag
state_dbg  output  3  current FSM state encoding, for debug only

Behaviour:
- Clock and reset: one clock, `clk`. Reset `reset` is asynchronous and active-high.
- Reset values: all synchroniser flops = 0; state = IDLE; counter = 0; door_motion_sensor = 0; sensor_fault = 0.
- Registered outputs: door_motion_sensor and sensor_fault are registered and change only on clk edges or on reset.
- Synchronised input: `s` = output of the last synchroniser stage. Raw input appears on `s` SYNC_STAGES edges after it is stable.
- State encodings: IDLE=0, QUALIFY=1, ACTIVE=2, HOLD=3, FAULT=4. Unused encodings go to IDLE on the next edge.
- IDLE: output 0. If s=1: go to QUALIFY with cnt=1. If DEBOUNCE_CYCLES=1: go straight to ACTIVE with output 1 and cnt=1.
- QUALIFY: output 0.
  - s=0: go to IDLE, cnt=0 (any glitch restarts qualification).
  - s=1 and cnt=DEBOUNCE_CYCLES-1: go to ACTIVE, output 1, cnt=1.
  - Otherwise: cnt+1.
- ACTIVE: output 1. cnt counts consecutive s=1 cycles.
  - s=0: go to HOLD, cnt=0.
  - s=1 and cnt=STUCK_CYCLES-1: go to FAULT, output 0, sensor_fault=1.
  - Otherwise: cnt+1.
- HOLD: output 1.
  - s=1: go to ACTIVE with cnt=1 (retrigger; hold and stuck counts both restart).
  - s=0 and cnt=HOLD_CYCLES-1: go to IDLE, output 0.
  - Otherwise: cnt+1.
- FAULT: output forced 0, sensor_fault=1. Leave only when clear_fault=1 and s=0 in the same cycle: go to IDLE with sensor_fault=0. A clear_fault while s=1 is ignored and the fault stays.
- clear_fault in any non-FAULT state: no effect.
- Latency, raw rise to output high: SYNC_STAGES + DEBOUNCE_CYCLES edges.
- Latency, s fall to output low: exactly HOLD_CYCLES edges after the edge that samples s=0 in ACTIVE (the transition edge into HOLD counts as hold cycle 0).
- Counter: a single CNT_W-bit counter is reused across states, is reloaded on every state change, and never wraps. The terminal comparisons above always fire before any overflow.
- Reset mid-operation: returns to IDLE and output 0 immediately (asynchronous). A sensor still held high must then re-qualify through the full debounce.
- Simultaneous events:
  - In HOLD, s=1 on the terminal-count cycle → ACTIVE wins and the output stays 1.
  - In ACTIVE, s=0 on the stuck-terminal cycle → HOLD wins and no fault is raised.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, STUCK_CYCLES=20):
- Reset asserted mid-cycle with raw_motion=1 → door_motion_sensor=0, sensor_fault=0, state_dbg=0 immediately. After release with raw still 1 → output 1 exactly 6 edges later.
- raw_motion pulses high 3 cycles, low 1 cycle, high 3 cycles → output never asserts; state_dbg returns to 0 between the pulses.
- raw high 10 cycles, then low → output high 6 edges after the rise. Output falls 8 edges after s is sampled low (HOLD exit to state 0).
- Retrigger: in HOLD at hold count 5, raw pulses high long enough for s=1 → state 2, output stays 1 continuously. The hold count restarts from 0 after s falls again.
- Stuck sensor: raw held high 40 cycles → sensor_fault=1 and output 0 on the 20th ACTIVE cycle. clear_fault pulsed with raw still high → fault stays. Lower raw, then pulse clear_fault → sensor_fault=0, state_dbg=0.
- Boundary: in HOLD, s rises exactly on the cycle cnt=7 → state goes to ACTIVE, not IDLE, with no output low glitch.
